prio_encoder_serial: RTL and testbench

- Parametrised, registered successor of the 4-to-2 priority encoder.
- Captures an N-bit request vector on a strobe, then emits the binary index of every set bit, one per valid/ready handshake.
- Highest index is emitted first; each emitted bit is cleared.
- Sits between interrupt/request sources and a single-consumer handler. Provides a valid flag and a last-code flag per capture burst.

---
 rtl/prio_encoder_serial.sv | 138 +++++++++++++
 tb/tb_prio_encoder_serial.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/prio_encoder_serial.sv
// rtl/prio_encoder_serial.sv - serial priority encoder: captures a request vector, emits set-bit indices one per handshake
//
// Purpose:
//   A req_vld strobe in IDLE captures req into a pending mask. The index of
//   each set bit is then emitted, one per out_vld/out_rdy handshake. Each
//   emitted bit is cleared from the mask.
//   By default the highest index is emitted first. When PENC_LOWFIRST_EN is
//   defined, the lowest index is emitted first. out_last and the clearing
//   rules are the same in both builds.
//
// Ports:
//   clk      in   rising-edge clock
//   rst_n    in   asynchronous active-low reset
//   req      in   [N-1:0] request vector, bit k = input k
//   req_vld  in   capture strobe; ignored unless idle
//   busy     out  a capture is pending
//   code     out  [W-1:0] index of the current pending bit
//   out_vld  out  code is valid
//   out_rdy  in   consumer accepts code
//   out_last out  code is the final pending bit of the burst
//   none     out  one-cycle pulse when req_vld is seen with req == 0 while idle
//
// Parameters:
//   N  number of request inputs (N >= 2)
//   W  code width, ceil(log2(N))
//
// Configuration macro:
//   PENC_LOWFIRST_EN  emit the lowest index first

module prio_encoder_serial #(
    parameter int N = 8,
    parameter int W = 3
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [N-1:0] req,
    input  logic         req_vld,
    output logic         busy,
    output logic [W-1:0] code,
    output logic         out_vld,
    input  logic         out_rdy,
    output logic         out_last,
    output logic         none
);

    typedef enum logic {
        IDLE = 1'b0,
        EMIT = 1'b1
    } state_t;

    localparam logic [N-1:0] ONE_N = {{(N-1){1'b0}}, 1'b1};

    state_t         state_q, state_d;
    logic [N-1:0]   mask_q, mask_d;
    logic [W-1:0]   code_q, code_d;
    logic           out_vld_q, out_vld_d;
    logic           out_last_q, out_last_d;
    logic           busy_q, busy_d;
    logic           none_q, none_d;

    // Index of the next bit to emit. The scan only visits bits below N,
    // so an out-of-range code cannot be produced.
    function automatic logic [W-1:0] pick(input logic [N-1:0] m);
        logic [W-1:0] idx;
        idx = '0;
`ifdef PENC_LOWFIRST_EN
        for (int i = N - 1; i >= 0; i--) begin
            if (m[i]) idx = W'(i);
        end
`else
        for (int i = 0; i < N; i++) begin
            if (m[i]) idx = W'(i);
        end
`endif
        return idx;
    endfunction

    always_comb begin
        state_d = state_q;
        mask_d  = mask_q;
        none_d  = 1'b0;

        case (state_q)
            IDLE: begin
                if (req_vld) begin
                    if (req != '0) begin
                        mask_d  = req;
                        state_d = EMIT;
                    end else begin
                        none_d = 1'b1;
                    end
                end
            end
            EMIT: begin
                // out_vld is always high in EMIT, so out_rdy alone completes the handshake.
                if (out_rdy) begin
                    mask_d = mask_q & ~(ONE_N << code_q);
                    if (mask_d == '0) state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // Outputs are computed from the next mask, so the registered
        // values line up with the state they describe.
        code_d     = pick(mask_d);
        out_last_d = (mask_d != '0) && ((mask_d & (mask_d - ONE_N)) == '0);
        out_vld_d  = (state_d == EMIT);
        busy_d     = (state_d == EMIT);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            mask_q     <= '0;
            code_q     <= '0;
            out_vld_q  <= 1'b0;
            out_last_q <= 1'b0;
            busy_q     <= 1'b0;
            none_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            mask_q     <= mask_d;
            code_q     <= code_d;
            out_vld_q  <= out_vld_d;
            out_last_q <= out_last_d;
            busy_q     <= busy_d;
            none_q     <= none_d;
        end
    end

    assign code     = code_q;
    assign out_vld  = out_vld_q;
    assign out_last = out_last_q;
    assign busy     = busy_q;
    assign none     = none_q;

endmodule

// File: tb/tb_prio_encoder_serial.sv
// tb/tb_prio_encoder_serial.sv - self-checking bench for prio_encoder_serial (N=8 and N=5 instances)

module tb_prio_encoder_serial;

    localparam int NA = 8;
    localparam int WA = 3;
    localparam int NB = 5;
    localparam int WB = 3;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [7:0]    req = '0;
    logic          req_vld = 1'b0;
    logic          out_rdy = 1'b1;
    logic          sel = 1'b0;

    logic          busy_a, out_vld_a, out_last_a, none_a;
    logic [WA-1:0] code_a;
    logic          busy_b, out_vld_b, out_last_b, none_b;
    logic [WB-1:0] code_b;

    logic          o_busy, o_vld, o_last, o_none;
    logic [2:0]    o_code;

    int n_chk  = 0;
    int n_fail = 0;
    int exp_q[$];

    always #5 clk = ~clk;

    prio_encoder_serial #(.N(NA), .W(WA)) u_dut_a (
        .clk(clk), .rst_n(rst_n), .req(req), .req_vld(req_vld & ~sel),
        .busy(busy_a), .code(code_a), .out_vld(out_vld_a), .out_rdy(out_rdy),
        .out_last(out_last_a), .none(none_a)
    );

    prio_encoder_serial #(.N(NB), .W(WB)) u_dut_b (
        .clk(clk), .rst_n(rst_n), .req(req[NB-1:0]), .req_vld(req_vld & sel),
        .busy(busy_b), .code(code_b), .out_vld(out_vld_b), .out_rdy(out_rdy),
        .out_last(out_last_b), .none(none_b)
    );

    assign o_busy = sel ? busy_b     : busy_a;
    assign o_vld  = sel ? out_vld_b  : out_vld_a;
    assign o_last = sel ? out_last_b : out_last_a;
    assign o_none = sel ? none_b     : none_a;
    assign o_code = sel ? code_b     : code_a;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_chk++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference order: list of set-bit indices, sorted by emission priority.
    function automatic void build(input logic [7:0] r, input int n);
        exp_q.delete();
`ifdef PENC_LOWFIRST_EN
        for (int i = 0; i < n; i++) if (r[i]) exp_q.push_back(i);
`else
        for (int i = n - 1; i >= 0; i--) if (r[i]) exp_q.push_back(i);
`endif
    endfunction

    task automatic chk_idle(input string tag);
        chk({tag, "_vld"},  o_vld,  0);
        chk({tag, "_busy"}, o_busy, 0);
        chk({tag, "_code"}, o_code, 0);
        chk({tag, "_last"}, o_last, 0);
        chk({tag, "_none"}, o_none, 0);
    endtask

    // rdy_mode: 0 = ready tied high, 1 = random ready, 2 = ready low for 3 cycles then high
    // strobe_mode: 0 = no strobes while emitting, 1 = random strobes, 2 = req_vld with 8'hFF every cycle
    task automatic run_burst(input logic s, input logic [7:0] r, input int rdy_mode, input int strobe_mode);
        int n;
        int cyc;
        n   = s ? NB : NA;
        sel = s;
        build(r, n);
        out_rdy = 1'b1;
        req     = r;
        req_vld = 1'b1;
        step();
        req_vld = 1'b0;
        req     = 8'($urandom);
        cyc = 0;
        while (exp_q.size() > 0 && cyc < 64) begin
            chk("emit_vld",  o_vld,  1);
            chk("emit_busy", o_busy, 1);
            chk("emit_code", o_code, exp_q[0]);
            chk("emit_last", o_last, exp_q.size() == 1);
            chk("emit_none", o_none, 0);
            case (rdy_mode)
                0:       out_rdy = 1'b1;
                1:       out_rdy = 1'($urandom_range(0, 1));
                default: out_rdy = (cyc >= 3);
            endcase
            case (strobe_mode)
                0:       begin req_vld = 1'b0; req = 8'($urandom); end
                1:       begin req_vld = 1'($urandom_range(0, 1)); req = 8'($urandom); end
                default: begin req_vld = 1'b1; req = 8'hFF; end
            endcase
            step();
            if (out_rdy) void'(exp_q.pop_front());
            cyc++;
        end
        chk("burst_bound", cyc < 64, 1);
        chk_idle("after_burst");
        req_vld = 1'b0;
        out_rdy = 1'b1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        chk("w_matches_n_a", WA, $clog2(NA));
        chk("w_matches_n_b", WB, $clog2(NB));

        // Reset held two cycles, then release.
        rst_n = 1'b0;
        step();
        step();
        chk_idle("in_reset");
        rst_n = 1'b1;
        step();
        chk_idle("after_reset");

        // Multi-bit capture, ready tied high.
        run_burst(1'b0, 8'b1010_0101, 0, 0);

        // Backpressure: three stalled cycles before acceptance.
        run_burst(1'b0, 8'b0001_0010, 2, 0);

        // Empty strobe while idle.
        req     = 8'h00;
        req_vld = 1'b1;
        step();
        req_vld = 1'b0;
        chk("empty_none", o_none, 1);
        chk("empty_vld",  o_vld,  0);
        chk("empty_busy", o_busy, 0);
        step();
        chk_idle("empty_after");

        // Full-mask strobes during emission must not recapture.
        run_burst(1'b0, 8'b0100_1001, 0, 2);

        // Async reset mid-burst, between clock edges.
        sel = 1'b0;
        build(8'hFF, NA);
        req     = 8'hFF;
        req_vld = 1'b1;
        out_rdy = 1'b1;
        step();
        req_vld = 1'b0;
        chk("ar_first_code", o_code, exp_q[0]);
        step();
        void'(exp_q.pop_front());
        chk("ar_second_code", o_code, exp_q[0]);
        chk("ar_second_vld",  o_vld,  1);
        #2;
        rst_n = 1'b0;
        #1;
        chk_idle("ar_in_reset");
        #2;
        rst_n = 1'b1;
        step();
        chk_idle("ar_released");
        run_burst(1'b0, 8'h01, 0, 0);

        // N=5 instance: codes never exceed 4.
        run_burst(1'b1, 8'b0001_0001, 0, 0);

        // Randomized bursts on both instances.
        for (int k = 0; k < 20; k++) begin
            run_burst(1'b0, 8'($urandom_range(1, 255)), 1, 1);
        end
        for (int k = 0; k < 10; k++) begin
            run_burst(1'b1, 8'($urandom_range(1, 31)), 1, 1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
